// File: rtl/secded_dec_seq.sv
// Sequential SECDED (16,11) decoder: reads NUM_WORDS codewords from byte memory, corrects/flags
// each one and writes {flags, 3'b0, data} back; 5 cycles per word, no backpressure on memory.
module secded_dec_seq #(
  parameter int NUM_WORDS = 15,
  parameter int SRC_BASE  = 30,
  parameter int DST_BASE  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rd_data,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data,
  output logic [4:0] sec_cnt,
  output logic [4:0] ded_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_LO, S_RD_HI, S_DECODE, S_WR_LO, S_WR_HI, S_DONE
  } state_t;

  // Codeword positions holding d1..d11.
  localparam logic [3:0] DPOS [0:10] = '{4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10,
                                         4'd11, 4'd12, 4'd13, 4'd14, 4'd15};

  state_t      r_state, w_next;
  logic [7:0]  r_idx;
  logic [15:0] r_cw;
  logic [15:0] r_out;
  logic [4:0]  r_sec, r_ded;

  logic [3:0]  w_syn;
  logic        w_par;
  logic [10:0] w_data;
  logic [1:0]  w_flags;
  logic [7:0]  w_src_lo, w_dst_lo;
  logic        w_last;
  logic        w_accept;

  assign w_src_lo = 8'(SRC_BASE) + {r_idx[6:0], 1'b0};
  assign w_dst_lo = 8'(DST_BASE) + {r_idx[6:0], 1'b0};
  assign w_last   = (r_idx == 8'(NUM_WORDS - 1));
  assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);

  always_comb begin
    w_syn = 4'd0;
    for (int k = 1; k < 16; k++) begin
      if (r_cw[k]) w_syn = w_syn ^ 4'(k);
    end
    w_par = ^r_cw;
    // A single error at a parity position (incl. p0) needs no data correction.
    for (int j = 0; j < 11; j++) begin
      w_data[j] = r_cw[DPOS[j]] ^ (w_par && (w_syn == DPOS[j]));
    end
    if (w_par)              w_flags = 2'b01;
    else if (w_syn != 4'd0) w_flags = 2'b10;
    else                    w_flags = 2'b00;
  end

  always_comb begin
    w_next      = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    mem_addr    = 8'd0;
    mem_wr_en   = 1'b0;
    mem_wr_data = 8'd0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_RD_LO;
      end
      S_RD_LO: begin
        busy     = 1'b1;
        mem_addr = w_src_lo;
        w_next   = S_RD_HI;
      end
      S_RD_HI: begin
        busy     = 1'b1;
        mem_addr = w_src_lo + 8'd1;
        w_next   = S_DECODE;
      end
      S_DECODE: begin
        busy   = 1'b1;
        w_next = S_WR_LO;
      end
      S_WR_LO: begin
        busy        = 1'b1;
        mem_addr    = w_dst_lo;
        mem_wr_en   = 1'b1;
        mem_wr_data = r_out[7:0];
        w_next      = S_WR_HI;
      end
      S_WR_HI: begin
        busy        = 1'b1;
        mem_addr    = w_dst_lo + 8'd1;
        mem_wr_en   = 1'b1;
        mem_wr_data = r_out[15:8];
        w_next      = w_last ? S_DONE : S_RD_LO;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) w_next = S_RD_LO;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= 8'd0;
      r_cw    <= 16'd0;
      r_out   <= 16'd0;
      r_sec   <= 5'd0;
      r_ded   <= 5'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_idx <= 8'd0;
        r_sec <= 5'd0;
        r_ded <= 5'd0;
      end
      case (r_state)
        S_RD_LO: r_cw[7:0]  <= mem_rd_data;
        S_RD_HI: r_cw[15:8] <= mem_rd_data;
        S_DECODE: begin
          r_out <= {w_flags, 3'b000, w_data};
          if (w_flags == 2'b01 && r_sec != 5'd31) r_sec <= r_sec + 5'd1;
          if (w_flags == 2'b10 && r_ded != 5'd31) r_ded <= r_ded + 5'd1;
        end
        S_WR_HI: if (!w_last) r_idx <= r_idx + 8'd1;
        default: ;
      endcase
    end
  end

  assign sec_cnt = r_sec;
  assign ded_cnt = r_ded;

endmodule
